// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared widths, FSM state encoding and grant select for the memory sequencer.
package mem_access_ctrl_pkg;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 8;
   localparam int CNT_W  = 3;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;
   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } gnt_t;
endpackage

// File: rtl/mem_access_ctrl_arb.sv
// mem_access_ctrl_arb: combinational fixed-priority 2:1 arbiter between fetch and load/store.
module mem_access_ctrl_arb
   import mem_access_ctrl_pkg::*;
#(
   parameter bit LS_PRIO = 1'b1
) (
   input  logic i_if_req,
   input  logic i_ls_req,
   output logic o_valid,
   output gnt_t o_gnt
);
   always_comb begin
      o_valid = i_if_req | i_ls_req;
      o_gnt   = (i_ls_req && (LS_PRIO || !i_if_req)) ? GNT_LS : GNT_IF;
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: IDLE/SETUP/ACCESS/DONE sequencer granting IF or LS access to a single-port memory.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int WAIT_CYC = 0,
   parameter bit LS_PRIO  = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_ack,
   output logic [DW-1:0] ls_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   inout  wire  [DW-1:0] mem_data,
   output logic          busy
);
   state_t           r_st;
   gnt_t             r_gnt;
   logic             r_we;
   logic [DW-1:0]    r_wdata;
   logic [CNT_W-1:0] r_cnt;
   logic [AW-1:0]    r_mem_addr;
   logic             r_mem_rd;
   logic             r_mem_wr;
   logic             r_if_ack;
   logic             r_ls_ack;
   logic [DW-1:0]    r_if_rdata;
   logic [DW-1:0]    r_ls_rdata;
   logic             w_valid;
   gnt_t             w_gnt;

   mem_access_ctrl_arb #(.LS_PRIO(LS_PRIO)) u_arb (
      .i_if_req(if_req),
      .i_ls_req(ls_req),
      .o_valid (w_valid),
      .o_gnt   (w_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st       <= IDLE;
         r_gnt      <= GNT_IF;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_mem_addr <= '0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_if_ack   <= 1'b0;
         r_ls_ack   <= 1'b0;
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
      end else begin
         case (r_st)
            IDLE: begin
               if (w_valid) begin
                  r_st       <= SETUP;
                  r_gnt      <= w_gnt;
                  r_mem_addr <= (w_gnt == GNT_LS) ? ls_addr : if_addr;
                  r_we       <= (w_gnt == GNT_LS) && ls_we;
                  r_wdata    <= ls_wdata;
               end
            end
            SETUP: begin
               r_st     <= ACCESS;
               r_cnt    <= CNT_W'(WAIT_CYC);
               r_mem_rd <= !r_we;
               r_mem_wr <= r_we;
            end
            ACCESS: begin
               // Final access cycle: sample the bus on the same edge the memory commits a write.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_st     <= DONE;
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  r_if_ack <= (r_gnt == GNT_IF);
                  r_ls_ack <= (r_gnt == GNT_LS);
                  if (!r_we && r_gnt == GNT_IF) r_if_rdata <= mem_data;
                  if (!r_we && r_gnt == GNT_LS) r_ls_rdata <= mem_data;
               end
            end
            DONE: begin
               r_st     <= IDLE;
               r_if_ack <= 1'b0;
               r_ls_ack <= 1'b0;
            end
         endcase
      end
   end

   assign mem_data = r_mem_wr ? r_wdata : {DW{1'bz}};
   assign mem_addr = r_mem_addr;
   assign mem_rd   = r_mem_rd;
   assign mem_wr   = r_mem_wr;
   assign if_ack   = r_if_ack;
   assign ls_ack   = r_ls_ack;
   assign if_rdata = r_if_rdata;
   assign ls_rdata = r_ls_rdata;
   assign busy     = (r_st != IDLE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench, instance 0 with WAIT_CYC=0 and instance 1 with WAIT_CYC=2.
module tb_mem_access_ctrl;
   typedef struct {
      int data;
      int ack_cyc;
      int first;
      int nrd;
      int nwr;
      int wdata;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   fin = 1'b0;
   bit   fin_done = 1'b0;

   logic       if_req_i[2];
   logic [4:0] if_addr_i[2];
   logic       ls_req_i[2];
   logic       ls_we_i[2];
   logic [4:0] ls_addr_i[2];
   logic [7:0] ls_wdata_i[2];
   logic       if_ack_o[2];
   logic       ls_ack_o[2];
   logic       mem_rd_o[2];
   logic       mem_wr_o[2];
   logic       busy_o[2];
   logic [7:0] if_rdata_o[2];
   logic [7:0] ls_rdata_o[2];
   logic [7:0] md_o[2];
   logic [4:0] mem_addr_o[2];

   ent_t q_if[2][$];
   ent_t q_ls[2][$];
   ent_t e_mon;
   int   nrd[2];
   int   nwr[2];
   int   first[2];
   int   wd[2];
   bit   p_if[2];
   bit   p_ls[2];
   int   exp_ls[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : gen
      wire  [7:0] mem_data;
      logic [7:0] mem [32];
      for (genvar b = 0; b < 8; b++) begin : pd
         pulldown (mem_data[b]);
      end
      initial for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'hA5;
      always @(posedge clk) if (mem_wr_o[g]) mem[mem_addr_o[g]] <= mem_data;
      assign mem_data = mem_rd_o[g] ? mem[mem_addr_o[g]] : 8'bz;
      assign md_o[g]  = mem_data;
      mem_access_ctrl #(.WAIT_CYC(g == 1 ? 2 : 0), .LS_PRIO(1'b1)) dut (
         .clk     (clk),
         .rst     (rst),
         .if_req  (if_req_i[g]),
         .if_addr (if_addr_i[g]),
         .if_ack  (if_ack_o[g]),
         .if_rdata(if_rdata_o[g]),
         .ls_req  (ls_req_i[g]),
         .ls_we   (ls_we_i[g]),
         .ls_addr (ls_addr_i[g]),
         .ls_wdata(ls_wdata_i[g]),
         .ls_ack  (ls_ack_o[g]),
         .ls_rdata(ls_rdata_o[g]),
         .mem_addr(mem_addr_o[g]),
         .mem_rd  (mem_rd_o[g]),
         .mem_wr  (mem_wr_o[g]),
         .mem_data(mem_data),
         .busy    (busy_o[g])
      );
   end

   function automatic int wc(input int g);
      return g == 1 ? 2 : 0;
   endfunction

   function automatic void chk(input string n, input int g, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h (cycle %0d)", n, g, a, e, cyc);
      end
   endfunction

   function automatic void score(input int g, input ent_t e);
      chk("ack_cycle", g, cyc, e.ack_cyc);
      chk("first_access", g, first[g], e.first);
      chk("rd_cycles", g, nrd[g], e.nrd);
      chk("wr_cycles", g, nwr[g], e.nwr);
      if (e.nwr > 0) chk("wr_data", g, wd[g], e.wdata);
   endfunction

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            chk("rst_ctl", g, int'({if_ack_o[g], ls_ack_o[g], mem_rd_o[g], mem_wr_o[g], busy_o[g]}), 0);
            chk("rst_data", g, int'({if_rdata_o[g], ls_rdata_o[g], md_o[g]}), 0);
            chk("rst_addr", g, int'(mem_addr_o[g]), 0);
            nrd[g] = 0; nwr[g] = 0; first[g] = -1; p_if[g] = 1'b0; p_ls[g] = 1'b0;
         end else begin
            chk("rd_wr_excl", g, int'(mem_rd_o[g] & mem_wr_o[g]), 0);
            if (!mem_rd_o[g] && !mem_wr_o[g]) chk("bus_z", g, int'(md_o[g]), 0);
            chk("if_ack_width", g, int'(if_ack_o[g] & p_if[g]), 0);
            chk("ls_ack_width", g, int'(ls_ack_o[g] & p_ls[g]), 0);
            if (mem_rd_o[g] || mem_wr_o[g]) begin
               if (first[g] < 0) first[g] = cyc;
               nrd[g] += int'(mem_rd_o[g]);
               nwr[g] += int'(mem_wr_o[g]);
               if (mem_wr_o[g]) wd[g] = int'(md_o[g]);
            end
            if (if_ack_o[g]) begin
               if (q_if[g].size() == 0) chk("if_ack_spurious", g, 1, 0);
               else begin
                  e_mon = q_if[g].pop_front();
                  chk("if_rdata", g, int'(if_rdata_o[g]), e_mon.data);
                  score(g, e_mon);
               end
            end
            if (ls_ack_o[g]) begin
               if (q_ls[g].size() == 0) chk("ls_ack_spurious", g, 1, 0);
               else begin
                  e_mon = q_ls[g].pop_front();
                  chk("ls_rdata", g, int'(ls_rdata_o[g]), e_mon.data);
                  score(g, e_mon);
               end
            end
            if (if_ack_o[g] || ls_ack_o[g]) begin
               nrd[g] = 0; nwr[g] = 0; first[g] = -1;
            end
            p_if[g] = if_ack_o[g];
            p_ls[g] = ls_ack_o[g];
         end
      end
      if (fin && !fin_done) begin
         fin_done = 1'b1;
         for (int g = 0; g < 2; g++) begin
            chk("if_pending", g, q_if[g].size(), 0);
            chk("ls_pending", g, q_ls[g].size(), 0);
         end
      end
   end

   task automatic do_req(input int g, input bit ls, input bit we, input logic [4:0] a,
                         input logic [7:0] wdv, input int exp, input int lat, input bit drop);
      ent_t e;
      @(negedge clk);
      e.data    = exp;
      e.ack_cyc = cyc + lat;
      e.first   = cyc + lat - 1 - wc(g);
      e.nrd     = we ? 0 : 1 + wc(g);
      e.nwr     = we ? 1 + wc(g) : 0;
      e.wdata   = int'(wdv);
      if (ls) begin
         ls_we_i[g] = we; ls_addr_i[g] = a; ls_wdata_i[g] = wdv; ls_req_i[g] = 1'b1;
         q_ls[g].push_back(e);
      end else begin
         if_addr_i[g] = a; if_req_i[g] = 1'b1;
         q_if[g].push_back(e);
      end
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (drop) begin
            if (ls) ls_req_i[g] = 1'b0;
            else if_req_i[g] = 1'b0;
         end
         if (ls ? ls_ack_o[g] : if_ack_o[g]) break;
      end
      if (ls) ls_req_i[g] = 1'b0;
      else if_req_i[g] = 1'b0;
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         if_req_i[g] = 1'b0; if_addr_i[g] = '0; ls_req_i[g] = 1'b0; ls_we_i[g] = 1'b0;
         ls_addr_i[g] = '0; ls_wdata_i[g] = '0; exp_ls[g] = 0;
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      do_req(0, 1'b0, 1'b0, 5'h03, 8'h00, 8'hA6, 3, 1'b0);
      do_req(0, 1'b1, 1'b1, 5'h1F, 8'h3C, exp_ls[0], 3, 1'b0);
      do_req(0, 1'b1, 1'b0, 5'h1F, 8'h00, 8'h3C, 3, 1'b0);
      exp_ls[0] = 8'h3C;
      fork
         do_req(0, 1'b1, 1'b0, 5'h00, 8'h00, 8'hA5, 3, 1'b0);
         do_req(0, 1'b0, 1'b0, 5'h07, 8'h00, 8'hA2, 7, 1'b0);
      join
      exp_ls[0] = 8'hA5;
      do_req(1, 1'b0, 1'b0, 5'h10, 8'h00, 8'hB5, 5, 1'b0);
      do_req(1, 1'b1, 1'b1, 5'h02, 8'h5A, exp_ls[1], 5, 1'b0);
      do_req(1, 1'b1, 1'b0, 5'h02, 8'h00, 8'h5A, 5, 1'b0);
      // Abort a store in its ACCESS cycle; the memory must keep its preload.
      @(negedge clk);
      ls_we_i[0] = 1'b1; ls_addr_i[0] = 5'h08; ls_wdata_i[0] = 8'hFF; ls_req_i[0] = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      ls_req_i[0] = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      exp_ls[0] = 0;
      exp_ls[1] = 0;
      do_req(0, 1'b1, 1'b0, 5'h08, 8'h00, 8'hAD, 3, 1'b0);
      do_req(0, 1'b0, 1'b0, 5'h1F, 8'h00, 8'h3C, 3, 1'b1);
      repeat (4) @(negedge clk);
      fin = 1'b1;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
